// File: rtl/aes_iter.sv
// Iterative AES encryptor: one round per clock through a shared 16-byte S-box datapath,
// with the key schedule rolled forward on the fly from an Nk-word window.
module aes_iter #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        state,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out,
  output logic                busy
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam logic [3:0] NR_L = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_iter: KEY_BITS must be 128, 192 or 256");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24]; a1 = a[23:16]; a2 = a[15:8]; a3 = a[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ROUND = 2'd2, DONE = 2'd3} st_t;

  st_t          st_q;
  logic [127:0] state_q, out_q, state_d;
  logic [31:0]  kw_q [NK];
  logic [31:0]  win_d [NK];
  logic [31:0]  nw [4];
  logic [7:0]   rcon_q;
  logic [3:0]   rnd_q, kpos_q, kpos_d;
  logic         out_valid_q, rot_hit, accept;
  logic [127:0] rk0, rk;

  assign in_ready  = (st_q == IDLE) || (st_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (st_q != IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign rk0       = {kw_q[0], kw_q[1], kw_q[2], kw_q[3]};
  assign rk        = {win_d[0], win_d[1], win_d[2], win_d[3]};
  assign kpos_d    = (int'(kpos_q) + 4 >= NK) ? 4'(int'(kpos_q) + 4 - NK) : kpos_q + 4'd4;

  // Four new schedule words per round; at most one of them needs SubWord (kpos = index mod Nk).
  always_comb begin
    int          sel;
    logic        rot;
    logic [31:0] chain, sub_in, sub_rot, sub_w, prev;
    sel = 4;
    rot = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      if (int'(kpos_q) + j == 0 || int'(kpos_q) + j == NK) begin
        sel = j;
        rot = 1'b1;
      end else if (NK == 8 && int'(kpos_q) + j == 4) begin
        sel = j;
        rot = 1'b0;
      end
    end
    chain  = kw_q[NK-1];
    sub_in = kw_q[NK-1];
    for (int j = 0; j < 4; j++) begin
      if (j == sel) sub_in = chain;
      chain = kw_q[j] ^ chain;
    end
    sub_rot = rot ? {sub_in[23:0], sub_in[31:24]} : sub_in;
    sub_w   = {sbox(sub_rot[31:24]), sbox(sub_rot[23:16]), sbox(sub_rot[15:8]), sbox(sub_rot[7:0])}
              ^ {(rot ? rcon_q : 8'h00), 24'h0};
    prev = kw_q[NK-1];
    for (int j = 0; j < 4; j++) begin
      nw[j] = kw_q[j] ^ ((j == sel) ? sub_w : prev);
      prev  = nw[j];
    end
    for (int m = 0; m < NK - 4; m++) win_d[m] = kw_q[m+4];
    for (int m = 0; m < 4; m++) win_d[NK-4+m] = nw[m];
    rot_hit = rot;
  end

  always_comb begin
    logic [127:0] sr, mc;
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sbox(state_q[127-8*(4*((c+r)%4)+r) -: 8]);
    for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    state_d = ((rnd_q == NR_L) ? sr : mc) ^ rk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      state_q     <= '0;
      out_q       <= '0;
      for (int m = 0; m < NK; m++) kw_q[m] <= '0;
      rcon_q      <= 8'h01;
      rnd_q       <= '0;
      kpos_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE: if (accept) begin
          state_q <= state;
          for (int m = 0; m < NK; m++) kw_q[m] <= key[KEY_BITS-1-32*m -: 32];
          st_q    <= LOAD;
        end
        LOAD: begin
          state_q <= state_q ^ rk0;
          rcon_q  <= 8'h01;
          rnd_q   <= 4'd1;
          kpos_q  <= '0;
          st_q    <= ROUND;
        end
        ROUND: begin
          state_q <= state_d;
          for (int m = 0; m < NK; m++) kw_q[m] <= win_d[m];
          kpos_q  <= kpos_d;
          if (rot_hit) rcon_q <= xt(rcon_q);
          rnd_q   <= rnd_q + 4'd1;
          if (rnd_q == NR_L) begin
            out_q       <= state_d;
            out_valid_q <= 1'b1;
            st_q        <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          if (in_valid) begin
            state_q <= state;
            for (int m = 0; m < NK; m++) kw_q[m] <= key[KEY_BITS-1-32*m -: 32];
            st_q    <= LOAD;
          end else begin
            st_q    <= IDLE;
          end
        end
        default: begin
          st_q        <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_iter.sv
// Randomised bench for aes_iter at all three key sizes against a FIPS-197 reference model.
module tb_aes_iter;
  logic         clk = 1'b0;
  logic         rst;
  logic         iv [3], ir [3], ov [3], orr [3], bz [3];
  logic [127:0] st_in [3], o [3];
  logic [255:0] key_in [3];
  logic [7:0]   sb [256];
  int           n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  aes_iter #(.KEY_BITS(128)) u128 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .state(st_in[0]), .key(key_in[0][255 -: 128]), .out_valid(ov[0]), .out_ready(orr[0]),
    .out(o[0]), .busy(bz[0]));
  aes_iter #(.KEY_BITS(192)) u192 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .state(st_in[1]), .key(key_in[1][255 -: 192]), .out_valid(ov[1]), .out_ready(orr[1]),
    .out(o[1]), .busy(bz[1]));
  aes_iter #(.KEY_BITS(256)) u256 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .state(st_in[2]), .key(key_in[2]), .out_valid(ov[2]), .out_ready(orr[2]),
    .out(o[2]), .busy(bz[2]));

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int nk_of(input int k);
    return 4 + 2*k;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    t = t << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] ky, input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [4][4], t [4][4];
    logic [7:0]   rc = 8'h01;
    logic [31:0]  tmp;
    logic [127:0] res;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = ky[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
      w[i] = w[i-nk] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rd < nr) begin
          s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
          s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
        end else
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        for (int r = 0; r < 4; r++) s[r][c] ^= w[4*rd+c][31-8*r -: 8];
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  task automatic run_one(input int k, input logic [127:0] pt, input logic [255:0] ky,
                         input logic [127:0] exp, input bit churn, input int hold, input string tag);
    int lat = 0;
    bit ok = 1'b1;
    @(negedge clk);
    check_eq({tag, " ready"}, {127'd0, ir[k]}, 128'd1);
    iv[k] = 1'b1; st_in[k] = pt; key_in[k] = ky; orr[k] = 1'b0;
    @(negedge clk);
    iv[k] = 1'b0;
    while (ov[k] !== 1'b1 && lat < 40) begin
      if (churn) begin
        st_in[k] = rnd128(); key_in[k] = {rnd128(), rnd128()}; iv[k] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    iv[k] = 1'b0;
    check_eq({tag, " latency"}, 128'(lat), 128'(nk_of(k) + 7));
    check_eq({tag, " out"}, o[k], exp);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!(ov[k] === 1'b1 && o[k] === exp && ir[k] === 1'b0 && bz[k] === 1'b1)) ok = 1'b0;
      end
      check_eq({tag, " held"}, {127'd0, ok}, 128'd1);
    end
    orr[k] = 1'b1;
    @(negedge clk);
    orr[k] = 1'b0;
    check_eq({tag, " idle"}, {125'd0, ov[k], bz[k], ir[k]}, 128'd1);
  endtask

  task automatic back_to_back(input int k);
    logic [127:0] pa, pb, ea, eb;
    logic [255:0] ka, kb;
    int lat = 0;
    pa = rnd128(); pb = rnd128(); ka = {rnd128(), rnd128()}; kb = {rnd128(), rnd128()};
    ea = aes_ref(pa, ka, nk_of(k)); eb = aes_ref(pb, kb, nk_of(k));
    @(negedge clk);
    iv[k] = 1'b1; st_in[k] = pa; key_in[k] = ka; orr[k] = 1'b1;
    @(negedge clk);
    st_in[k] = pb; key_in[k] = kb;
    while (ov[k] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    check_eq($sformatf("b2b k%0d first latency", k), 128'(lat), 128'(nk_of(k) + 7));
    check_eq($sformatf("b2b k%0d first out", k), o[k], ea);
    check_eq($sformatf("b2b k%0d ready in done", k), {127'd0, ir[k]}, 128'd1);
    @(negedge clk);
    iv[k] = 1'b0;
    check_eq($sformatf("b2b k%0d second accepted", k), {126'd0, ov[k], bz[k]}, 128'd1);
    lat = 0;
    while (ov[k] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    check_eq($sformatf("b2b k%0d second latency", k), 128'(lat), 128'(nk_of(k) + 7));
    check_eq($sformatf("b2b k%0d second out", k), o[k], eb);
    @(negedge clk);
    orr[k] = 1'b0;
    check_eq($sformatf("b2b k%0d idle", k), {125'd0, ov[k], bz[k], ir[k]}, 128'd1);
  endtask

  task automatic reset_mid_round();
    logic [127:0] pt = rnd128();
    logic [255:0] ky = {rnd128(), rnd128()};
    bit quiet = 1'b1;
    @(negedge clk);
    iv[0] = 1'b1; st_in[0] = pt; key_in[0] = ky;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst async flags", {125'd0, ov[0], bz[0], ir[0]}, 128'd1);
    check_eq("rst async out", o[0], 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (ov[0] !== 1'b0) quiet = 1'b0;
    end
    check_eq("rst no out_valid", {127'd0, quiet}, 128'd1);
    pt = rnd128(); ky = {rnd128(), rnd128()};
    run_one(0, pt, ky, aes_ref(pt, ky, 4), 1'b0, 0, "after rst");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] kat_key;
    logic [127:0] pt;
    logic [255:0] ky;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; orr[k] = 1'b0; st_in[k] = '0; key_in[k] = '0;
    end
    build_sbox();
    #2;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("reset k%0d out_valid", k), {127'd0, ov[k]}, 128'd0);
      check_eq($sformatf("reset k%0d in_ready", k), {127'd0, ir[k]}, 128'd1);
      check_eq($sformatf("reset k%0d busy", k), {127'd0, bz[k]}, 128'd0);
      check_eq($sformatf("reset k%0d out", k), o[k], 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    run_one(0, 128'h3243f6a8885a308d313198a2e0370734,
            {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
            128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 0, "fips k128");
    kat_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    run_one(0, 128'h00112233445566778899aabbccddeeff, kat_key,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 0, "kat k128");
    run_one(1, 128'h00112233445566778899aabbccddeeff, kat_key,
            128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b0, 0, "kat k192");
    run_one(2, 128'h00112233445566778899aabbccddeeff, kat_key,
            128'h8ea2b7ca516745bfeafc49904b496089, 1'b0, 0, "kat k256");

    pt = rnd128(); ky = {rnd128(), rnd128()};
    run_one(1, pt, ky, aes_ref(pt, ky, 6), 1'b0, 20, "backpressure k192");

    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 3; n++) begin
        pt = rnd128(); ky = {rnd128(), rnd128()};
        run_one(k, pt, ky, aes_ref(pt, ky, nk_of(k)), n == 1, int'($urandom_range(0, 3)),
                $sformatf("rand k%0d n%0d", k, n));
      end

    back_to_back(0);
    back_to_back(2);
    reset_mid_round();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_iter.md
AES_ITER -- requirements
Module: aes_iter

Interface
REQ-001 SHALL have parameter: KEY_BITS, default 128, AES key length; legal values 128, 192, 256, any other value is an elaboration error.
REQ-002 SHALL have derived constant NR = 10/12/14 for KEY_BITS = 128/192/256.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  state/key offered.
REQ-006 SHALL have port: in_ready  output  1  core can accept a block.
REQ-007 SHALL have port: state  input  128  plaintext, byte 0 in bits [127:120].
REQ-008 SHALL have port: key  input  KEY_BITS  cipher key, byte 0 in MSBs.
REQ-009 SHALL have port: out_valid  output  1  ciphertext held on out.
REQ-010 SHALL have port: out_ready  input  1  consumer takes out.
REQ-011 SHALL have port: out  output  128  ciphertext, same byte order as state.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FIPS-197 encryption iteratively: one round per clock, one shared 16-byte SubBytes datapath, on-the-fly key expansion (no stored schedule).
REQ-014 SHALL use FSM states IDLE, LOAD, ROUND, DONE; any unused encoding returns to IDLE.
REQ-015 SHALL assert in_ready only in IDLE, and in DONE in the cycle where out_ready is high (back-to-back accept).
REQ-016 SHALL accept a block on the edge where in_valid & in_ready; state and key are captured on that edge; later changes on those inputs have no effect.
REQ-017 LOAD (1 cycle): SHALL compute the round-0 AddRoundKey (state ^ first 128 key bits) and initialise the key-expansion registers and round counter to 1.
REQ-018 ROUND: SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey for rounds 1..NR-1 and omit MixColumns in round NR; the counter increments each cycle; after round NR the FSM enters DONE.
REQ-019 SHALL give a latency, from accept edge to first cycle with out_valid high, of exactly NR+1 clocks: 11, 13 or 15.
REQ-020 DONE: SHALL hold out_valid high and out stable until out_ready is sampled high.
REQ-021 DONE with out_ready high and in_valid low: SHALL enter IDLE and drop out_valid next cycle.
REQ-022 DONE with out_ready and in_valid both high: SHALL complete the hand-off and accept the new block on the same edge, then enter LOAD; no bubble beyond LOAD.
REQ-023 SHALL keep out at the last ciphertext while not in DONE; its value is don't-care for consumers.
REQ-024 KEY_BITS = 192/256: SHALL produce round-key words with the Nk-word recurrence (RotWord/SubWord/Rcon every Nk words; extra SubWord at i mod 8 = 4 for 256); round keys not aligned to 128-bit boundaries are assembled from the rolling word window.
REQ-025 Rcon SHALL be generated by a GF(2^8) doubling register (x^8+x^4+x^3+x+1), reset to 8'h01 at each LOAD.
REQ-026 SHALL ignore in_valid in LOAD and ROUND (in_ready low); no input is dropped silently because no accept occurs.

Reset
REQ-027 SHALL drive, while rst is high: FSM=IDLE, out_valid=0, in_ready=1, busy=0, out=128'h0, round counter=0, key registers=0, immediately and independent of clk.
REQ-028 On rst asserted mid-operation, the in-flight block SHALL be discarded with no out_valid pulse; the first accept after rst deassertion behaves as from power-up.
REQ-029 After rst deassertion, SHALL be ready to accept on the first clk edge.

Verification
REQ-030 KEY_BITS=128, state=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> out=3925841d02dc09fbdc118597196a0b32, out_valid exactly 11 clocks after accept.
REQ-031 KEY_BITS=128/192/256, state=00112233445566778899aabbccddeeff, key=000102...(16/24/32 bytes) -> 69c4e0d86a7b0430d8cdb78070b4c55a / dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089, latency 11/13/15.
REQ-032 Back-pressure: out_ready held low 20 cycles -> out_valid and out stable throughout, in_ready low; on out_ready high for 1 cycle -> hand-off, then IDLE.
REQ-033 Back-to-back: in_valid held high with two vectors, out_ready high -> second accepted on the DONE edge of the first; both results correct; accepts spaced NR+2 clocks apart.
REQ-034 Reset mid-round: assert rst at round 5 -> outputs at reset values asynchronously, no out_valid; the next vector after release gives the correct result.
REQ-035 Input churn: change state/key every cycle after accept -> result matches the captured values only.
